min_max_decoder: RTL and testbench

MIN_MAX_DECODER -- requirements
Module: min_max_decoder

---
 rtl/min_max_pkg.sv | 20 ++
 rtl/min_max_decoder.sv | 179 +++++++++++++++++
 tb/tb_min_max_decoder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/min_max_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : min_max_pkg                                              |
// | Description : Shared types and constants for the LED bar min/max       |
// |               decoder: FSM state encoding and default index width.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package min_max_pkg;

   // Default width of a decoded LED index; the bar is 2**VALSIZE LEDs wide.
   localparam int unsigned VALSIZE_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : min_max_pkg
`default_nettype wire

// File: rtl/min_max_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : min_max_decoder                                          |
// | Description : Captures an LED bar and scans it one bit per cycle,      |
// |               reporting the lowest/highest lit index, the number of    |
// |               lit LEDs and empty/full/contiguous flags.                |
// | Ports       : clk_i     - clock, rising edge                           |
// |               rst_ni    - asynchronous active-low reset                |
// |               leds_i    - LED bar to decode (2**VALSIZE bits)          |
// |               start_i   - capture leds_i and start a decode            |
// |               busy_o    - decode in progress (SCAN or DONE)            |
// |               done_o    - one-cycle pulse, results valid               |
// |               lo_o/hi_o - lowest / highest lit index                   |
// |               count_o   - number of lit LEDs (VALSIZE+1 bits)          |
// |               empty_o/full_o/contig_o - result flags                   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module min_max_decoder
   import min_max_pkg::*;
#(
   parameter int unsigned VALSIZE = VALSIZE_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [2**VALSIZE-1:0] leds_i,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [VALSIZE-1:0]    lo_o,
   output logic [VALSIZE-1:0]    hi_o,
   output logic [VALSIZE:0]      count_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic                  contig_o
);

   localparam int unsigned NLEDS = 2**VALSIZE;
   // Terminal index value (== number of LEDs); also the "all lit" count.
   localparam logic [VALSIZE:0] IDX_END = {1'b1, {VALSIZE{1'b0}}};
   localparam logic [VALSIZE:0] CNT_ONE = (VALSIZE+1)'(1);

   state_e               state_q,  state_d;
   logic [NLEDS-1:0]     leds_q,   leds_d;
   logic [VALSIZE:0]     idx_q,    idx_d;
   logic [VALSIZE-1:0]   acc_lo_q, acc_lo_d;
   logic [VALSIZE-1:0]   acc_hi_q, acc_hi_d;
   logic [VALSIZE:0]     acc_cnt_q, acc_cnt_d;
   logic                 seen_q,   seen_d;   // a 1 has been seen
   logic                 hole_q,   hole_d;   // a 0 has followed a 1
   logic                 gap_q,    gap_d;    // a 1 has followed such a 0
   logic [VALSIZE-1:0]   lo_q,     lo_d;
   logic [VALSIZE-1:0]   hi_q,     hi_d;
   logic [VALSIZE:0]     cnt_q,    cnt_d;
   logic                 empty_q,  empty_d;
   logic                 full_q,   full_d;
   logic                 contig_q, contig_d;

   logic [VALSIZE-1:0]   cur_idx;
   logic                 cur_bit;

   assign cur_idx = idx_q[VALSIZE-1:0];
   assign cur_bit = leds_q[cur_idx];

   always_comb begin
      state_d   = state_q;
      leds_d    = leds_q;
      idx_d     = idx_q;
      acc_lo_d  = acc_lo_q;
      acc_hi_d  = acc_hi_q;
      acc_cnt_d = acc_cnt_q;
      seen_d    = seen_q;
      hole_d    = hole_q;
      gap_d     = gap_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      cnt_d     = cnt_q;
      empty_d   = empty_q;
      full_d    = full_q;
      contig_d  = contig_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               leds_d    = leds_i;
               idx_d     = '0;
               acc_lo_d  = '0;
               acc_hi_d  = '0;
               acc_cnt_d = '0;
               seen_d    = 1'b0;
               hole_d    = 1'b0;
               gap_d     = 1'b0;
               state_d   = ST_SCAN;
            end
         end
         ST_SCAN: begin
            // The counter parks at IDX_END after the last bit; that terminal
            // cycle commits the accumulators to the held result set on the
            // way into DONE, so results are already valid while done_o is up.
            if (idx_q == IDX_END) begin
               lo_d     = acc_lo_q;
               hi_d     = acc_hi_q;
               cnt_d    = acc_cnt_q;
               empty_d  = (acc_cnt_q == '0);
               full_d   = (acc_cnt_q == IDX_END);
               contig_d = (acc_cnt_q != '0) && !gap_q;
               state_d  = ST_DONE;
            end else begin
               idx_d = idx_q + CNT_ONE;
               if (cur_bit) begin
                  if (!seen_q) begin
                     acc_lo_d = cur_idx;
                  end
                  acc_hi_d  = cur_idx;
                  acc_cnt_d = acc_cnt_q + CNT_ONE;
                  seen_d    = 1'b1;
                  if (hole_q) begin
                     gap_d = 1'b1;
                  end
               end else if (seen_q) begin
                  hole_d = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         leds_q    <= '0;
         idx_q     <= '0;
         acc_lo_q  <= '0;
         acc_hi_q  <= '0;
         acc_cnt_q <= '0;
         seen_q    <= 1'b0;
         hole_q    <= 1'b0;
         gap_q     <= 1'b0;
         lo_q      <= '0;
         hi_q      <= '0;
         cnt_q     <= '0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         contig_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         leds_q    <= leds_d;
         idx_q     <= idx_d;
         acc_lo_q  <= acc_lo_d;
         acc_hi_q  <= acc_hi_d;
         acc_cnt_q <= acc_cnt_d;
         seen_q    <= seen_d;
         hole_q    <= hole_d;
         gap_q     <= gap_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         cnt_q     <= cnt_d;
         empty_q   <= empty_d;
         full_q    <= full_d;
         contig_q  <= contig_d;
      end
   end

   assign busy_o   = (state_q != ST_IDLE);
   assign done_o   = (state_q == ST_DONE);
   assign lo_o     = lo_q;
   assign hi_o     = hi_q;
   assign count_o  = cnt_q;
   assign empty_o  = empty_q;
   assign full_o   = full_q;
   assign contig_o = contig_q;

endmodule : min_max_decoder
`default_nettype wire

// File: tb/tb_min_max_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_min_max_decoder                                       |
// | Description : Self-checking bench for min_max_decoder (VALSIZE=4):     |
// |               reference model plus per-cycle compare and directed      |
// |               vectors with literal expectations.                       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_min_max_decoder;

   localparam int VS = 4;
   localparam int NL = 2**VS;

   logic          clk_i   = 1'b0;
   logic          rst_ni  = 1'b0;
   logic [NL-1:0] leds_i  = '0;
   logic          start_i = 1'b0;
   logic          busy_o, done_o, empty_o, full_o, contig_o;
   logic [VS-1:0] lo_o, hi_o;
   logic [VS:0]   count_o;

   int checks = 0;
   int errors = 0;

   min_max_decoder #(.VALSIZE(VS)) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .leds_i   (leds_i),
      .start_i  (start_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .lo_o     (lo_o),
      .hi_o     (hi_o),
      .count_o  (count_o),
      .empty_o  (empty_o),
      .full_o   (full_o),
      .contig_o (contig_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int lo, hi, cnt, empty, full, contig;
   } res_t;

   function automatic res_t decode(input logic [NL-1:0] v);
      res_t r;
      r.lo = 0; r.hi = 0;
      r.cnt = $countones(v);
      for (int i = NL-1; i >= 0; i--) if (v[i]) r.lo = i;
      for (int i = 0; i < NL; i++)     if (v[i]) r.hi = i;
      r.empty  = (r.cnt == 0);
      r.full   = (r.cnt == NL);
      // contiguous: shifting the bar down to its lowest LED leaves a solid run
      r.contig = (r.cnt != 0) &&
                 ((32'(v) >> r.lo) == ((32'd1 << r.cnt) - 32'd1));
      return r;
   endfunction

   // Cycles of busy remaining after an accepted start: 17 to reach the done
   // cycle, plus the done cycle itself.
   int            m_rem = 0;
   logic [NL-1:0] m_val = '0;
   res_t          m_res = '{0, 0, 0, 1, 0, 0};

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_rem <= 0;
         m_res <= '{0, 0, 0, 1, 0, 0};
      end else if (m_rem == 0) begin
         if (start_i) begin
            m_val <= leds_i;
            m_rem <= NL + 2;
         end
      end else begin
         m_rem <= m_rem - 1;
         if (m_rem == 2) m_res <= decode(m_val);
      end
   end

   always @(negedge clk_i) begin
      chk("busy",   int'(busy_o),   int'(m_rem != 0));
      chk("done",   int'(done_o),   int'(m_rem == 1));
      chk("lo",     int'(lo_o),     m_res.lo);
      chk("hi",     int'(hi_o),     m_res.hi);
      chk("count",  int'(count_o),  m_res.cnt);
      chk("empty",  int'(empty_o),  m_res.empty);
      chk("full",   int'(full_o),   m_res.full);
      chk("contig", int'(contig_o), m_res.contig);
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_done(input string tag, output int lat);
      int n;
      bit got;
      n = 1; got = 1'b0;
      while (n <= 40 && !got) begin
         @(posedge clk_i); #1;
         if (done_o) got = 1'b1; else n++;
      end
      lat = got ? n : -1;
      chk({tag, "_latency"}, lat, NL + 1);
   endtask

   task automatic check_lit(input string tag, input int xlo, input int xhi,
                            input int xcnt, input int xe, input int xf,
                            input int xc);
      chk({tag, "_lo"},     int'(lo_o),     xlo);
      chk({tag, "_hi"},     int'(hi_o),     xhi);
      chk({tag, "_count"},  int'(count_o),  xcnt);
      chk({tag, "_empty"},  int'(empty_o),  xe);
      chk({tag, "_full"},   int'(full_o),   xf);
      chk({tag, "_contig"}, int'(contig_o), xc);
   endtask

   task automatic run_vec(input string tag, input logic [NL-1:0] v,
                          input int xlo, input int xhi, input int xcnt,
                          input int xe, input int xf, input int xc);
      int lat;
      @(posedge clk_i); #1;
      leds_i  = v;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      leds_i  = ~v;            // post-capture changes must not matter
      wait_done(tag, lat);
      check_lit(tag, xlo, xhi, xcnt, xe, xf, xc);
      @(posedge clk_i); #1;
      chk({tag, "_idle_after"}, int'(busy_o), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int dcount;
      repeat (2) @(posedge clk_i);
      #1;
      check_lit("reset", 0, 0, 0, 1, 0, 0);
      chk("reset_busy", int'(busy_o), 0);
      rst_ni = 1'b1;
      repeat (2) @(posedge clk_i);

      run_vec("v0FF8", 16'h0FF8, 3, 11,  9, 0, 0, 1);
      run_vec("v0000", 16'h0000, 0,  0,  0, 1, 0, 0);
      run_vec("vFFFF", 16'hFFFF, 0, 15, 16, 0, 1, 1);
      run_vec("v0108", 16'h0108, 3,  8,  2, 0, 0, 0);
      run_vec("v8000", 16'h8000, 15, 15, 1, 0, 0, 1);
      run_vec("vA5A5", 16'hA5A5, 0, 15,  8, 0, 0, 0);
      run_vec("v0001", 16'h0001, 0,  0,  1, 0, 0, 1);

      // start pulse during SCAN is ignored, capture is not disturbed
      @(posedge clk_i); #1;
      leds_i = 16'h0001; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      leds_i = 16'hFFFF; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      chk("ign_busy_mid", int'(busy_o), 1);
      begin
         int n;
         bit got;
         n = 6; got = 1'b0;
         while (n <= 40 && !got) begin
            @(posedge clk_i); #1;
            if (done_o) got = 1'b1; else n++;
         end
         chk("ign_latency", got ? n : -1, NL + 1);
      end
      check_lit("ign", 0, 0, 1, 0, 0, 1);
      chk("ign_busy_done", int'(busy_o), 1);
      @(posedge clk_i); #1;
      chk("ign_busy_end", int'(busy_o), 0);

      // reset in the middle of a scan aborts it
      @(posedge clk_i); #1;
      leds_i = 16'h00F0; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      #1;
      check_lit("abort", 0, 0, 0, 1, 0, 0);
      chk("abort_busy", int'(busy_o), 0);
      dcount = 0;
      repeat (3) begin
         @(posedge clk_i); #1;
         if (done_o) dcount++;
      end
      rst_ni = 1'b1;
      repeat (20) begin
         @(posedge clk_i); #1;
         if (done_o) dcount++;
      end
      chk("abort_no_done", dcount, 0);
      check_lit("abort_held", 0, 0, 0, 1, 0, 0);

      run_vec("post_rst", 16'h0FF8, 3, 11, 9, 0, 0, 1);

      repeat (3) @(posedge clk_i);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_min_max_decoder
`default_nettype wire
